// File: rtl/tick_level_pkg.sv
// tick_level_pkg: shared state encodings and a constant clog2 helper for tick_to_level
package tick_level_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_HIGH = 2'd1;
    localparam logic [ST_W-1:0] ST_LOW  = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: up/down counter that holds at all-ones and at zero; inc and dec together cancel
module sat_updown_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat_hit
);

    assign sat_hit = &count;

    // count moves only when exactly one of inc/dec is asserted and the limit allows it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && !dec && !sat_hit)
            count <= count + 1'b1;
        else if (dec && !inc && count != '0)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/tick_to_level.sv
// tick_to_level: stretches single-cycle ticks into HIGH_CYCLES pulses with a LOW_CYCLES gap; define TICK_TO_LEVEL_QUEUE_EN to queue busy ticks
module tick_to_level
    import tick_level_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic level,
    output logic busy,
    output logic drop
);

    localparam int MAX_C  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW_RAW = clog2(MAX_C);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] H_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] L_LOAD = CW'(LOW_CYCLES - 1);

    if (HIGH_CYCLES < 1 || LOW_CYCLES < 1 || PEND_W < 1) begin : g_bad_params
        $error("tick_to_level: HIGH_CYCLES, LOW_CYCLES and PEND_W must all be >= 1");
    end

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            low_exit;
    logic            busy_tick;
    logic            pend_go;
    logic            drop_n;

    // the final LOW cycle is the one point where a new pulse may start while busy
    assign low_exit  = (state == ST_LOW) && (cnt == '0);
    assign busy_tick = tick && ((state == ST_HIGH) || ((state == ST_LOW) && !low_exit));

`ifdef TICK_TO_LEVEL_QUEUE_EN
    logic [PEND_W-1:0] pend;
    logic              pend_full;
    logic              pend_inc;
    logic              pend_dec;

    assign pend_go  = (pend != '0);
    assign pend_inc = busy_tick && !pend_full;
    assign pend_dec = low_exit && pend_go && !tick;
    assign drop_n   = busy_tick && pend_full;

    sat_updown_counter #(.W(PEND_W)) u_pend (
        .clk    (clk),
        .reset  (reset),
        .inc    (pend_inc),
        .dec    (pend_dec),
        .count  (pend),
        .sat_hit(pend_full)
    );
`else
    assign pend_go = 1'b0;
    assign drop_n  = busy_tick;
`endif

    // next-state and down-counter reload; the illegal encoding falls back to IDLE
    always_comb begin
        state_n = ST_IDLE;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                state_n = tick ? ST_HIGH : ST_IDLE;
                cnt_n   = tick ? H_LOAD : cnt;
            end
            ST_HIGH: begin
                state_n = (cnt == '0) ? ST_LOW : ST_HIGH;
                cnt_n   = (cnt == '0) ? L_LOAD : cnt - 1'b1;
            end
            ST_LOW: begin
                state_n = !low_exit ? ST_LOW : (tick || pend_go) ? ST_HIGH : ST_IDLE;
                cnt_n   = !low_exit ? cnt - 1'b1 : (tick || pend_go) ? H_LOAD : '0;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // state, counter and Moore outputs all register together so the outputs never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= (state_n == ST_HIGH);
            busy  <= (state_n != ST_IDLE);
            drop  <= drop_n;
        end
    end

endmodule

// File: tb/tb_tick_to_level.sv
// tb_tick_to_level: table vectors, hand sequences and random ticks checked against a remaining-time model
module tb_tick_to_level;

    localparam int H    = 4;
    localparam int L    = 2;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    typedef struct {
        logic tk;
        logic lv;
        logic bz;
        logic dr;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic level;
    logic busy;
    logic drop;

    int   n_vec = 0;
    int   n_bad = 0;
    int   m_rem = 0;
    int   m_pend = 0;
    logic m_drop = 1'b0;
    int   n_tick = 0;
    int   n_drop = 0;
    int   n_det = 0;
    logic level_q = 1'b0;

    vec_t tbl1[20];
    vec_t tbl4[32];

    tick_to_level #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW)) dut (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .level(level),
        .busy (busy),
        .drop (drop)
    );

    always #5 clk = ~clk;

    // downstream rising-edge detector used for the loopback count
    always @(posedge clk) begin
        if (level && !level_q) n_det <= n_det + 1;
        level_q <= level;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // m_rem counts busy cycles left including the current one; level is high in the first H of them
    task automatic model_step(input logic t);
        m_drop = 1'b0;
        if (m_rem == 0) begin
            if (t) m_rem = H + L;
        end else if (m_rem == 1) begin
            if (t || m_pend > 0) begin
                if (!t) m_pend--;
                m_rem = H + L;
            end else begin
                m_rem = 0;
            end
        end else begin
            if (t) begin
`ifdef TICK_TO_LEVEL_QUEUE_EN
                if (m_pend < PMAX) m_pend++;
                else m_drop = 1'b1;
`else
                m_drop = 1'b1;
`endif
            end
            m_rem--;
        end
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_pend = 0;
        m_drop = 1'b0;
    endtask

    task automatic cyc(input logic t, input string tag);
        chk({tag, ".level"}, level, m_rem > L);
        chk({tag, ".busy"}, busy, m_rem != 0);
        chk({tag, ".drop"}, drop, m_drop);
        n_drop += int'(drop);
        n_tick += int'(t);
        tick = t;
        @(posedge clk);
        model_step(t);
        #1;
    endtask

    task automatic seq(input logic [63:0] pat, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(pat[i], tag);
    endtask

    task automatic run_table1();
        for (int c = 0; c < 20; c++) begin
            chk("t1.level", level, tbl1[c].lv);
            chk("t1.busy", busy, tbl1[c].bz);
            chk("t1.drop", drop, tbl1[c].dr);
            tick = tbl1[c].tk;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_table4();
        for (int c = 0; c < 32; c++) begin
            chk("t4.level", level, tbl4[c].lv);
            chk("t4.busy", busy, tbl4[c].bz);
            chk("t4.drop", drop, tbl4[c].dr);
            tick = tbl4[c].tk;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   det0;
        int   tick0;
        int   drop0;
        int   guard;
        logic [63:0] pat;

        for (int c = 0; c < 20; c++)
            tbl1[c] = '{c == 10, c >= 11 && c <= 14, c >= 11 && c <= 16, 1'b0};
        for (int c = 0; c < 32; c++) begin
`ifdef TICK_TO_LEVEL_QUEUE_EN
            tbl4[c] = '{c == 10 || c == 12 || c == 16,
                        (c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26),
                        c >= 11 && c <= 28, 1'b0};
`else
            tbl4[c] = '{c == 10 || c == 12 || c == 16,
                        (c >= 11 && c <= 14) || (c >= 17 && c <= 20),
                        c >= 11 && c <= 22, c == 13};
`endif
        end

        #12;
        chk("reset.level", level, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.drop", drop, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_table1();
        run_table4();

        model_reset();
        pat = '0;
        pat[10] = 1'b1;
        pat[12] = 1'b1;
        seq(pat, 30, "two_ticks");

        pat = '0;
        for (int i = 10; i <= 14; i++) pat[i] = 1'b1;
        seq(pat, 40, "burst");

        cyc(1'b1, "pre_reset");
        cyc(1'b1, "pre_reset");
        cyc(1'b1, "pre_reset");
        #3;
        tick = 1'b0;
        reset = 1'b1;
        #1;
        chk("async.level", level, 1'b0);
        chk("async.busy", busy, 1'b0);
        chk("async.drop", drop, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        pat = '0;
        pat[8] = 1'b1;
        seq(pat, 24, "post_reset");

        det0  = n_det;
        tick0 = n_tick;
        drop0 = n_drop;
        guard = 0;
        while (n_tick - tick0 < 200 && guard < 5000) begin
            cyc($urandom_range(2) == 0, "random");
            guard++;
        end
        if (guard >= 5000) begin
            n_vec++;
            n_bad++;
            $display("FAIL random.budget: got %0d ticks required 200", n_tick - tick0);
        end
        for (int i = 0; i < 60; i++) cyc(1'b0, "drain");
        n_vec++;
        if (n_det - det0 != (n_tick - tick0) - (n_drop - drop0)) begin
            n_bad++;
            $display("FAIL loopback: got %0d edges expected %0d", n_det - det0,
                     (n_tick - tick0) - (n_drop - drop0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_to_level.md
Name: tick_to_level

Overview:
- Converts single-cycle `tick` pulses into a clean level waveform.
- Each accepted tick produces exactly one high pulse of HIGH_CYCLES, followed by a guaranteed low gap of LOW_CYCLES.
- A downstream Mealy edge detector therefore regenerates exactly one tick per accepted input tick.
- Sits at the transmit end of level-signalled strobes: slow-domain handshakes, LED or indicator drive, loopback against the edge detector.

Parameters:
- HIGH_CYCLES, 4, cycles `level` is held high per pulse; must be ≥1.
- LOW_CYCLES, 2, minimum cycles `level` is held low after each pulse; must be ≥1.
- PEND_W, 3, width of the pending-tick counter; saturates at 2**PEND_W-1. Only used with TICK_TO_LEVEL_QUEUE_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  single-cycle request strobe, sampled on the rising edge of clk.
- level  output  1  registered stretched level.
- busy  output  1  registered; high whenever state ≠ IDLE.
- drop  output  1  registered one-cycle pulse; high in the cycle after a tick that was discarded.

Behaviour:
- Reset: all outputs and internal registers clear asynchronously.
  - state=IDLE, level=0, busy=0, drop=0, pend=0, cnt=0.
  - Reset mid-pulse forces level low immediately; queued ticks are lost.
- States and encoding: IDLE (0), HIGH (1), LOW (2). Encoding 3 is illegal and recovers to IDLE next cycle with level=0.
- Down-counter cnt: width clog2(max(HIGH_CYCLES, LOW_CYCLES)), minimum 1 bit.
- IDLE: if tick, go to HIGH and load cnt=HIGH_CYCLES-1.
- HIGH: decrement cnt each cycle. When cnt==0, go to LOW and load cnt=LOW_CYCLES-1.
- LOW: decrement cnt each cycle. When cnt==0:
  - if pend>0 or tick, go to HIGH and load cnt=HIGH_CYCLES-1;
  - otherwise go to IDLE.
- Outputs are Moore: level=(state==HIGH), busy=(state≠IDLE), both registered with the state.
- Timing for a tick sampled in cycle k with the FSM idle:
  - level high in cycles k+1 .. k+HIGH_CYCLES;
  - level low in cycles k+HIGH_CYCLES+1 .. k+HIGH_CYCLES+LOW_CYCLES;
  - busy high over k+1 .. k+HIGH_CYCLES+LOW_CYCLES;
  - a new tick is accepted directly again from cycle k+HIGH_CYCLES+LOW_CYCLES+1.
- Busy ticks: a tick arriving in HIGH or LOW (other than the LOW-exit case above) is handled per the optional feature.
- Simultaneous events with queue enabled: on LOW exit with pend>0 and tick=1, the increment and decrement cancel, so pend is unchanged.
- The low gap is never shortened. level never stays high across two pulses.

Optional Feature:
- Macro: TICK_TO_LEVEL_QUEUE_EN.
- Defined:
  - A busy tick increments pend. At saturation (2**PEND_W-1) the tick is discarded instead and drop=1 in the following cycle.
  - pend decrements on each LOW→HIGH transition taken because pend>0 (i.e. with tick=0).
- Undefined:
  - No pend register exists.
  - Every busy tick is discarded with drop=1 next cycle, except a tick arriving in the final LOW cycle, which is accepted.

Decomposition:
- Shared package tick_level_pkg:
  - state encodings ST_IDLE, ST_HIGH, ST_LOW and the state width (2);
  - a clog2 helper constant function.
- One natural sub-module: sat_updown_counter.
  - Saturating up/down counter with inc, dec, sat_hit and count outputs.
  - Instantiated only under TICK_TO_LEVEL_QUEUE_EN.

Test Plan (defaults HIGH_CYCLES=4, LOW_CYCLES=2 unless stated):
1. Single tick at cycle 10 -> level=1 in cycles 11–14, level=0 in 15–16, busy=1 in 11–16, IDLE at 17, drop never asserts.
2. Queue on, ticks at 10 and 12 -> pulses in 11–14 and 17–20, low gap 15–16, pend peaks at 1, drop=0.
3. Queue on, PEND_W=2, ticks at 10–14 -> tick 10 accepted, ticks 11–13 queued (pend=3), tick 14 dropped with drop=1 at 15; four pulses, each followed by a 2-cycle gap.
4. Queue off, ticks at 10, 12 and 16 (final LOW cycle) -> tick 12 dropped with drop=1 at 13; tick 16 accepted, giving pulses in 11–14 and 17–20.
5. Async reset asserted mid-cycle 12 during HIGH -> level and busy drop to 0 without waiting for a clock edge, pend=0; tick at 20 -> normal pulse in 21–24.
6. Loopback: level drives edge_detect_mealy, 200 random ticks -> count of detector ticks equals count of accepted ticks, i.e. input ticks minus drop pulses.
